// File: rtl/dp_pkg.sv
// Shared definitions for the multi-lane dot-product engine.
//   - FSM state encoding (IDLE/READ/DRAIN/DONE)
//   - DRAIN_CYC: cycles spent letting the RAM/product/accumulate pipeline empty
//   - clog2: constant-evaluable ceiling log2 used for port and counter widths
package dp_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int DRAIN_CYC = 3;

  // clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, ...
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dp_bank_ram.sv
// One element bank: WORDS x DATA_W, one write port, one synchronous read port
// (read data appears the cycle after the address). Contents are not reset.
// Ports:
//   clk    clock
//   we     write strobe
//   waddr  write word address
//   wdata  write data
//   raddr  read word address
//   rdata  registered read data
module dp_bank_ram #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 512,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dotprod_multilane.sv
// Multi-lane dot-product engine: sum(A[i]*B[i]) for i<n, LANES MACs per cycle.
// Element i lives in bank i%LANES at word i/LANES (one A and one B bank per lane).
// Pipeline: P0 address issue -> P1 RAM data -> P2 masked lane products -> P3 acc.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   init_we/sel/addr/data host element write (sel 0 = A, 1 = B); only honoured in IDLE
//   start                 1-cycle request, sampled in IDLE only
//   n                     element count (clamped to DEPTH), latched at start
//   signed_md, accum_md   signed multiply / add onto previous result, latched at start
//   busy                  high while reading and draining
//   done                  1-cycle pulse, result valid from this cycle
//   result                accumulator, held until the next accepted start or rst
module dotprod_multilane
  import dp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int DEPTH  = 1024,
  parameter int ACC_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_we,
  input  logic                  init_sel,
  input  logic [clog2(DEPTH)-1:0] init_addr,
  input  logic [DATA_W-1:0]     init_data,
  input  logic                  start,
  input  logic [clog2(DEPTH):0] n,
  input  logic                  signed_md,
  input  logic                  accum_md,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_W-1:0]      result
);

  localparam int AW     = clog2(DEPTH);
  localparam int NW     = AW + 1;
  localparam int LG_L   = clog2(LANES);
  localparam int WORDS  = DEPTH / LANES;
  localparam int WA     = clog2(WORDS);
  localparam int PW     = 2 * DATA_W;
  localparam int STAGES = 1;

  logic [1:0]    state, state_nxt;
  logic [NW-1:0] n_q, n_clamp, beats, beat, beat_p1;
  logic [1:0]    dcnt;
  logic          sgn_q, issue, wr_ok;
  logic [STAGES:0] vld_pipe;   // [0]: RAM data valid, [1]: lane products valid
  logic [ACC_W-1:0] acc, lane_sum;
  logic [WA-1:0] rd_addr, wr_word;

  logic [LANES-1:0][DATA_W-1:0] a_rd, b_rd;
  logic [LANES-1:0][ACC_W-1:0]  lane_prod, prod_q;

  assign n_clamp = (n > NW'(DEPTH)) ? NW'(DEPTH) : n;
  assign beats   = (n_q + NW'(LANES - 1)) >> LG_L;
  assign rd_addr = WA'(beat);
  assign wr_word = WA'(init_addr >> LG_L);
  assign wr_ok   = init_we && (state == IDLE);
  assign result  = acc;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic          hit;
    logic [PW-1:0] ps, pu;
    logic [NW-1:0] idx;

    assign hit = (init_addr & AW'(LANES - 1)) == AW'(l);

    dp_bank_ram #(.DATA_W(DATA_W), .WORDS(WORDS), .AW(WA)) u_bank_a (
      .clk(clk), .we(wr_ok && !init_sel && hit), .waddr(wr_word),
      .wdata(init_data), .raddr(rd_addr), .rdata(a_rd[l]));

    dp_bank_ram #(.DATA_W(DATA_W), .WORDS(WORDS), .AW(WA)) u_bank_b (
      .clk(clk), .we(wr_ok && init_sel && hit), .waddr(wr_word),
      .wdata(init_data), .raddr(rd_addr), .rdata(b_rd[l]));

    assign ps  = PW'($signed(a_rd[l])) * PW'($signed(b_rd[l]));
    assign pu  = PW'(a_rd[l]) * PW'(b_rd[l]);
    // element index of this lane in the beat now leaving the RAM; lanes past n
    // read stale words of the last beat and must contribute nothing
    assign idx = (beat_p1 << LG_L) | NW'(l);
    assign lane_prod[l] = (idx < n_q) ? (sgn_q ? ACC_W'($signed(ps)) : ACC_W'(pu))
                                      : '0;
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + prod_q[l];
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (n == '0) ? DONE : READ;
      READ:  if (beat == beats - NW'(1)) state_nxt = DRAIN;
      DRAIN: if (dcnt == 2'(DRAIN_CYC - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    issue = (state == READ);
    busy  = (state == READ) || (state == DRAIN);
  end

  // datapath: counters, pipeline, accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      sgn_q    <= 1'b0;
      beat     <= '0;
      beat_p1  <= '0;
      dcnt     <= '0;
      vld_pipe <= '0;
      prod_q   <= '0;
      acc      <= '0;
      done     <= 1'b0;
    end else begin
      done     <= (state == DONE);
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      beat_p1  <= beat;
      prod_q   <= lane_prod;
      if (vld_pipe[1]) acc <= acc + lane_sum;
      case (state)
        IDLE: if (start) begin
          n_q   <= n_clamp;
          sgn_q <= signed_md;
          beat  <= '0;
          if (!accum_md) acc <= '0;
        end
        READ: begin
          beat <= beat + NW'(1);
          dcnt <= '0;
        end
        DRAIN: dcnt <= dcnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dotprod_multilane.sv
// Randomized + directed bench for dotprod_multilane (LANES=2, DEPTH=16).
// Reference: element arrays and a 64-bit arithmetic sum over the first n elements.
module tb_dotprod_multilane;

  localparam int DATA_W = 32;
  localparam int LANES  = 2;
  localparam int DEPTH  = 16;
  localparam int ACC_W  = 64;
  localparam int AW     = 4;
  localparam int NW     = 5;

  logic clk = 1'b0;
  logic rst, init_we, init_sel, start, signed_md, accum_md;
  logic [AW-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [NW-1:0] n;
  logic busy, done;
  logic [ACC_W-1:0] result;

  int errs = 0;
  int checks = 0;
  logic [31:0] ma [DEPTH];
  logic [31:0] mb [DEPTH];
  logic [63:0] mres;

  dotprod_multilane #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .init_we(init_we), .init_sel(init_sel), .init_addr(init_addr),
    .init_data(init_data), .start(start), .n(n), .signed_md(signed_md), .accum_md(accum_md),
    .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input logic [31:0] d);
    init_we = 1'b1; init_sel = sel; init_addr = AW'(addr); init_data = d;
    tick();
    init_we = 1'b0;
    if (sel) mb[addr] = d; else ma[addr] = d;
  endtask

  function automatic logic [63:0] model(input int nn, input bit sg, input bit ac,
                                        input logic [63:0] prev);
    logic [63:0] s;
    int m;
    m = (nn > DEPTH) ? DEPTH : nn;
    s = ac ? prev : 64'd0;
    for (int i = 0; i < m; i++) begin
      if (sg) s += 64'(longint'($signed(ma[i])) * longint'($signed(mb[i])));
      else    s += {32'd0, ma[i]} * {32'd0, mb[i]};
    end
    return s;
  endfunction

  // poke: during busy, try a write to A[0] and a second start (both must be ignored)
  // wr_same: write A[1]=10 in the same cycle as start (must land before the reads)
  task automatic run(input string tag, input int nn, input bit sg, input bit ac,
                     input bit poke, input bit wr_same);
    int lat, bc, m, beats;
    logic [63:0] exp;
    m = (nn > DEPTH) ? DEPTH : nn;
    beats = (m + LANES - 1) / LANES;
    n = NW'(nn); signed_md = sg; accum_md = ac; start = 1'b1;
    if (wr_same) begin
      init_we = 1'b1; init_sel = 1'b0; init_addr = AW'(1); init_data = 32'd10;
      ma[1] = 32'd10;
    end
    exp = model(nn, sg, ac, mres);
    tick();
    start = 1'b0; init_we = 1'b0;
    lat = 0; bc = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bc++;
      if (poke && lat == 1) begin
        init_we = 1'b1; init_sel = 1'b0; init_addr = '0; init_data = 32'd99;
        start = 1'b1; n = NW'(1);
      end
      tick();
      lat++;
      init_we = 1'b0; start = 1'b0;
    end
    chk({tag, "_lat"}, 64'(lat), 64'((m == 0) ? 1 : beats + 4));
    chk({tag, "_busy"}, 64'(bc), 64'((m == 0) ? 0 : beats + 3));
    chk({tag, "_res"}, result, exp);
    mres = exp;
    tick();
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dcnt, k, nn;
    rst = 1'b1; init_we = 1'b0; init_sel = 1'b0; init_addr = '0; init_data = '0;
    start = 1'b0; n = '0; signed_md = 1'b0; accum_md = 1'b0;
    mres = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res", result, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, 32'd0);
      wr(1'b1, i, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, 32'(i + 1));
      wr(1'b1, i, 32'(i + 5));
    end

    run("c1", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c1_lit", result, 64'd70);
    run("c2", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c2_lit", result, 64'd38);
    run("c4a", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    run("c4b", 3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("c4b_lit", result, 64'd108);
    run("c4c", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c4c_lit", result, 64'd0);

    wr(1'b0, 0, 32'hFFFF_FFFF);
    wr(1'b1, 0, 32'd3);
    run("c3s", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("c3s_lit", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run("c3u", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c3u_lit", result, 64'h0000_0002_FFFF_FFFD);

    // reset in the middle of a run
    wr(1'b0, 0, 32'd1);
    wr(1'b1, 0, 32'd5);
    n = NW'(4); signed_md = 1'b0; accum_md = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c5_busy", 64'(busy), 64'd0);
    chk("c5_res", result, 64'd0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    chk("c5_nodone", 64'(dcnt), 64'd0);
    mres = '0;
    run("c5r", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c5r_lit", result, 64'd70);

    run("c6", 4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("c6_lit", result, 64'd70);
    run("c6r", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c6r_lit", result, 64'd70);

    run("sw", 4, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sw_lit", result, 64'd118);

    for (int it = 0; it < 30; it++) begin
      k = int'($urandom_range(0, 4));
      for (int j = 0; j < k; j++)
        wr(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), $urandom);
      nn = (it % 7 == 6) ? 31 : int'($urandom_range(0, 20));
      run("rnd", nn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
